// File: rtl/cache_assoc_wt_if.sv
// Cache bus bundle: CPU load/store port, flush control, memory port and statistics.
// master = CPU plus memory environment, slave = the cache itself.
interface cache_assoc_wt_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ready;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_hit;
    logic              busy;
    logic              flush;
    logic              flush_done;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic [31:0]       hit_count;
    logic [31:0]       miss_count;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, flush, mem_ack, mem_rdata,
        input  cpu_ready, cpu_rdata, cpu_hit, busy, flush_done,
               mem_req, mem_we, mem_addr, mem_wdata, hit_count, miss_count
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, flush, mem_ack, mem_rdata,
        output cpu_ready, cpu_rdata, cpu_hit, busy, flush_done,
               mem_req, mem_we, mem_addr, mem_wdata, hit_count, miss_count
    );
endinterface

// File: rtl/cache_assoc_wt.sv
// N-way write-through, no-write-allocate cache with per-set round-robin victims and flush sweep.
// Hit completes 2 cycles after accept; misses/stores wait on mem_ack; requests accepted only in IDLE.
module cache_assoc_wt #(
    parameter int WAYS   = 4,
    parameter int SETS   = 64,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input logic               clk,
    input logic               rst_n,
    cache_assoc_wt_if.slave   bus
);
    localparam int IDX_W = $clog2(SETS);
    localparam int WAY_W = $clog2(WAYS);
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    typedef enum logic [2:0] {IDLE, LOOKUP, MEM_RD, MEM_WR, FLUSH} state_e;
    state_e state_q, state_d;

    logic [WAYS-1:0]   valid_q [SETS], valid_d [SETS];
    logic [WAY_W-1:0]  rr_q    [SETS], rr_d    [SETS];
    logic [TAG_W-1:0]  tag_q   [SETS][WAYS], tag_d  [SETS][WAYS];
    logic [DATA_W-1:0] data_q  [SETS][WAYS], data_d [SETS][WAYS];

    logic [ADDR_W-3:0] req_word_q, req_word_d;
    logic              req_we_q, req_we_d;
    logic [DATA_W-1:0] req_wdata_q, req_wdata_d;
    logic              lk_hit_q, lk_hit_d;
    logic [IDX_W-1:0]  flush_idx_q, flush_idx_d;

    logic              cpu_ready_q, cpu_ready_d, cpu_hit_q, cpu_hit_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic              busy_q, busy_d, flush_done_q, flush_done_d;
    logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [31:0]       hit_count_q, hit_count_d, miss_count_q, miss_count_d;

    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic              lk_hit;
    logic [WAY_W-1:0]  lk_way, vic_way;
    logic              unused_addr_bits;

    // Blocks are one word, so the byte offset never reaches the cache state.
    assign unused_addr_bits = ^bus.cpu_addr[1:0];
    assign idx = req_word_q[IDX_W-1:0];
    assign tag = req_word_q[ADDR_W-3:IDX_W];

    always_comb begin
        lk_hit  = 1'b0;
        lk_way  = '0;
        vic_way = rr_q[idx];
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[idx][w]) vic_way = WAY_W'(w);
        end
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[idx][w] && tag_q[idx][w] == tag) begin
                lk_hit = 1'b1;
                lk_way = WAY_W'(w);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.flush) state_d = FLUSH;
                     else if (bus.cpu_req) state_d = LOOKUP;
            LOOKUP:  if (req_we_q) state_d = MEM_WR;
                     else if (lk_hit) state_d = IDLE;
                     else state_d = MEM_RD;
            MEM_RD,
            MEM_WR:  if (bus.mem_ack) state_d = IDLE;
            FLUSH:   if (flush_idx_q == IDX_W'(SETS - 1)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        valid_d      = valid_q;
        rr_d         = rr_q;
        tag_d        = tag_q;
        data_d       = data_q;
        req_word_d   = req_word_q;
        req_we_d     = req_we_q;
        req_wdata_d  = req_wdata_q;
        lk_hit_d     = lk_hit_q;
        flush_idx_d  = flush_idx_q;
        cpu_ready_d  = 1'b0;
        cpu_hit_d    = 1'b0;
        cpu_rdata_d  = cpu_rdata_q;
        flush_done_d = 1'b0;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        busy_d       = (state_d != IDLE);
        case (state_q)
            IDLE: begin
                if (bus.flush) begin
                    flush_idx_d = '0;
                end else if (bus.cpu_req) begin
                    req_word_d  = bus.cpu_addr[ADDR_W-1:2];
                    req_we_d    = bus.cpu_we;
                    req_wdata_d = bus.cpu_wdata;
                end
            end
            LOOKUP: begin
                lk_hit_d   = lk_hit;
                mem_addr_d = {req_word_q, 2'b00};
                if (req_we_q) begin
                    if (lk_hit) data_d[idx][lk_way] = req_wdata_q;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_wdata_d = req_wdata_q;
                end else if (lk_hit) begin
                    cpu_rdata_d = data_q[idx][lk_way];
                    cpu_ready_d = 1'b1;
                    cpu_hit_d   = 1'b1;
                    hit_count_d = hit_count_q + 32'd1;
                end else begin
                    mem_req_d = 1'b1;
                    mem_we_d  = 1'b0;
                end
            end
            MEM_RD: begin
                if (bus.mem_ack) begin
                    valid_d[idx][vic_way] = 1'b1;
                    tag_d[idx][vic_way]   = tag;
                    data_d[idx][vic_way]  = bus.mem_rdata;
                    // Pointer only advances when a valid line is actually displaced.
                    if (&valid_q[idx]) rr_d[idx] = rr_q[idx] + 1'b1;
                    cpu_rdata_d  = bus.mem_rdata;
                    cpu_ready_d  = 1'b1;
                    miss_count_d = miss_count_q + 32'd1;
                    mem_req_d    = 1'b0;
                end
            end
            MEM_WR: begin
                if (bus.mem_ack) begin
                    cpu_ready_d = 1'b1;
                    cpu_hit_d   = lk_hit_q;
                    if (lk_hit_q) hit_count_d  = hit_count_q + 32'd1;
                    else          miss_count_d = miss_count_q + 32'd1;
                    mem_req_d = 1'b0;
                end
            end
            FLUSH: begin
                valid_d[flush_idx_q] = '0;
                rr_d[flush_idx_q]    = '0;
                flush_idx_d          = flush_idx_q + 1'b1;
                if (flush_idx_q == IDX_W'(SETS - 1)) flush_done_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                rr_q[s]    <= '0;
            end
            req_word_q   <= '0;
            req_we_q     <= 1'b0;
            req_wdata_q  <= '0;
            lk_hit_q     <= 1'b0;
            flush_idx_q  <= '0;
            cpu_ready_q  <= 1'b0;
            cpu_hit_q    <= 1'b0;
            cpu_rdata_q  <= '0;
            busy_q       <= 1'b0;
            flush_done_q <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            rr_q         <= rr_d;
            req_word_q   <= req_word_d;
            req_we_q     <= req_we_d;
            req_wdata_q  <= req_wdata_d;
            lk_hit_q     <= lk_hit_d;
            flush_idx_q  <= flush_idx_d;
            cpu_ready_q  <= cpu_ready_d;
            cpu_hit_q    <= cpu_hit_d;
            cpu_rdata_q  <= cpu_rdata_d;
            busy_q       <= busy_d;
            flush_done_q <= flush_done_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    // Tags and data are qualified by valid bits, so they need no reset.
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

    assign bus.cpu_ready  = cpu_ready_q;
    assign bus.cpu_hit    = cpu_hit_q;
    assign bus.cpu_rdata  = cpu_rdata_q;
    assign bus.busy       = busy_q;
    assign bus.flush_done = flush_done_q;
    assign bus.mem_req    = mem_req_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.hit_count  = hit_count_q;
    assign bus.miss_count = miss_count_q;
endmodule

// File: tb/tb_cache_assoc_wt.sv
// Directed plus random bench for cache_assoc_wt against a set/way table model.
module tb_cache_assoc_wt;
    localparam int WAYS = 4;
    localparam int SETS = 64;
    localparam logic [31:0] PAT = 32'hA5A5_A5A5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cache_assoc_wt_if #(.ADDR_W(32), .DATA_W(32)) bus ();
    cache_assoc_wt #(.WAYS(WAYS), .SETS(SETS), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: the cache as a table of lines per set plus a replacement pointer.
    typedef struct { bit v; logic [23:0] tag; logic [31:0] data; } line_t;
    line_t m_line [SETS][WAYS];
    int    m_rr   [SETS];
    int    e_hits, e_miss;

    task automatic model_flush();
        for (int s = 0; s < SETS; s++) begin
            m_rr[s] = 0;
            for (int w = 0; w < WAYS; w++) m_line[s][w].v = 1'b0;
        end
    endtask

    task automatic model_access(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                                output bit hit, output logic [31:0] rd);
        int s, way, vic;
        logic [23:0] t;
        s = int'(addr[7:2]);
        t = addr[31:8];
        way = -1;
        rd = '0;
        for (int w = 0; w < WAYS; w++)
            if (m_line[s][w].v && m_line[s][w].tag == t) way = w;
        hit = (way >= 0);
        if (hit) e_hits++; else e_miss++;
        if (we) begin
            if (hit) m_line[s][way].data = wd;
        end else if (hit) begin
            rd = m_line[s][way].data;
        end else begin
            rd = {addr[31:2], 2'b00} ^ PAT;
            vic = -1;
            for (int w = WAYS - 1; w >= 0; w--) if (!m_line[s][w].v) vic = w;
            if (vic < 0) begin
                vic = m_rr[s];
                m_rr[s] = (m_rr[s] + 1) % WAYS;
            end
            m_line[s][vic].v = 1'b1;
            m_line[s][vic].tag = t;
            m_line[s][vic].data = rd;
        end
    endtask

    // Memory: ack mem_lat cycles after mem_req is first seen, data = addr ^ PAT.
    int          mem_lat = 1;
    int          mem_txn = 0;
    int          wait_cnt = 0;
    logic        rec_we;
    logic [31:0] rec_addr, rec_wdata;

    initial begin
        bus.mem_ack = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (bus.mem_ack) begin
                bus.mem_ack = 1'b0;
            end else if (bus.mem_req && rst_n) begin
                if (wait_cnt >= mem_lat) begin
                    bus.mem_ack = 1'b1;
                    bus.mem_rdata = bus.mem_addr ^ PAT;
                    rec_we = bus.mem_we;
                    rec_addr = bus.mem_addr;
                    rec_wdata = bus.mem_wdata;
                    mem_txn++;
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    task automatic do_req(input bit we, input logic [31:0] addr, input logic [31:0] wd, input string tag);
        bit eh, got;
        logic [31:0] ed;
        int lat, txn0;
        @(negedge clk);
        bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wd;
        txn0 = mem_txn;
        @(posedge clk);
        #1;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'($urandom);
        bus.cpu_addr = $urandom; bus.cpu_wdata = $urandom;
        model_access(we, addr, wd, eh, ed);
        got = 1'b0;
        lat = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (bus.cpu_ready) begin
                got = 1'b1;
                lat = i;
                break;
            end
        end
        check({tag, " ready_seen"}, 64'(got), 64'd1);
        if (got) begin
            check({tag, " latency"}, 64'(lat), 64'((eh && !we) ? 2 : 3 + mem_lat));
            check({tag, " cpu_hit"}, 64'(bus.cpu_hit), 64'(eh));
            if (!we) check({tag, " rdata"}, 64'(bus.cpu_rdata), 64'(ed));
            check({tag, " hit_count"}, 64'(bus.hit_count), 64'(e_hits));
            check({tag, " miss_count"}, 64'(bus.miss_count), 64'(e_miss));
            check({tag, " mem_req_low"}, 64'(bus.mem_req), 64'd0);
            check({tag, " mem_txns"}, 64'(mem_txn - txn0), 64'((eh && !we) ? 0 : 1));
            if (!(eh && !we)) begin
                check({tag, " mem_we"}, 64'(rec_we), 64'(we));
                check({tag, " mem_addr"}, 64'(rec_addr), 64'({addr[31:2], 2'b00}));
                if (we) check({tag, " mem_wdata"}, 64'(rec_wdata), 64'(wd));
            end
        end
    endtask

    task automatic do_flush(input bit poke, input string tag);
        int busy_cnt, done_at, side;
        @(negedge clk);
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        model_flush();
        busy_cnt = 0; done_at = 0; side = 0;
        for (int i = 1; i <= 90; i++) begin
            @(negedge clk);
            if (poke && i == 10) begin
                bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h100;
            end
            if (poke && i == 14) bus.cpu_req = 1'b0;
            if (bus.mem_req || bus.cpu_ready) side++;
            if (bus.busy) busy_cnt++;
            if (bus.flush_done) begin
                done_at = i;
                break;
            end
        end
        check({tag, " busy_cycles"}, 64'(busy_cnt), 64'd64);
        check({tag, " done_at"}, 64'(done_at), 64'd65);
        check({tag, " no_side_activity"}, 64'(side), 64'd0);
        @(negedge clk);
        check({tag, " done_pulse"}, 64'(bus.flush_done), 64'd0);
        check({tag, " idle_after"}, 64'(bus.busy), 64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " cpu_ready"}, 64'(bus.cpu_ready), 64'd0);
        check({tag, " cpu_rdata"}, 64'(bus.cpu_rdata), 64'd0);
        check({tag, " cpu_hit"}, 64'(bus.cpu_hit), 64'd0);
        check({tag, " busy"}, 64'(bus.busy), 64'd0);
        check({tag, " flush_done"}, 64'(bus.flush_done), 64'd0);
        check({tag, " mem_req"}, 64'(bus.mem_req), 64'd0);
        check({tag, " mem_we"}, 64'(bus.mem_we), 64'd0);
        check({tag, " mem_addr"}, 64'(bus.mem_addr), 64'd0);
        check({tag, " mem_wdata"}, 64'(bus.mem_wdata), 64'd0);
        check({tag, " hit_count"}, 64'(bus.hit_count), 64'd0);
        check({tag, " miss_count"}, 64'(bus.miss_count), 64'd0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        logic [31:0] a;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.flush = 1'b0;
        model_flush();
        e_hits = 0; e_miss = 0;
        repeat (3) @(negedge clk);
        check_all_zero("reset_held");
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("reset_released");

        do_req(1'b0, 32'h100, '0, "t1_load_miss");
        check("t1 rdata_const", 64'(bus.cpu_rdata), 64'h0000_0000_A5A5_A4A5);
        check("t1 miss_count_const", 64'(bus.miss_count), 64'd1);
        do_req(1'b0, 32'h100, '0, "t2_reuse");
        check("t2 hit_count_const", 64'(bus.hit_count), 64'd1);

        do_req(1'b0, 32'h200, '0, "t3_fill200");
        do_req(1'b0, 32'h300, '0, "t3_fill300");
        do_req(1'b0, 32'h400, '0, "t3_fill400");
        do_req(1'b0, 32'h500, '0, "t3_evict500");
        do_req(1'b0, 32'h300, '0, "t3_hit300");
        do_req(1'b0, 32'h100, '0, "t3_reload100");
        do_req(1'b0, 32'h700, '0, "t3_evict_rr2");
        do_req(1'b0, 32'h300, '0, "t3_after300");
        do_req(1'b0, 32'h400, '0, "t3_after400");

        do_req(1'b0, 32'h200, '0, "t4_load200");
        do_req(1'b1, 32'h200, 32'hDEAD_BEEF, "t4_store_hit");
        do_req(1'b0, 32'h200, '0, "t4_reload");
        check("t4 rdata_const", 64'(bus.cpu_rdata), 64'h0000_0000_DEAD_BEEF);

        do_req(1'b1, 32'h604, 32'h1234_5678, "t5_store_miss");
        do_req(1'b0, 32'h604, '0, "t5_load_after");

        mem_lat = 0;
        do_req(1'b0, 32'h808, '0, "zero_wait_miss");
        mem_lat = 1;

        do_flush(1'b1, "t6_flush");
        do_req(1'b0, 32'h100, '0, "t6_after100");
        do_req(1'b0, 32'h604, '0, "t6_after604");

        // Reset while a read miss is outstanding.
        mem_lat = 20;
        @(negedge clk);
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h0000_0A00;
        @(posedge clk);
        #1;
        bus.cpu_req = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.mem_req) begin
                seen = 1'b1;
                break;
            end
        end
        check("t6 rst_mem_req_seen", 64'(seen), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6 rst_mem_req_async", 64'(bus.mem_req), 64'd0);
        check("t6 rst_busy_async", 64'(bus.busy), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_flush();
        e_hits = 0; e_miss = 0;
        mem_lat = 1;
        @(negedge clk);
        check_all_zero("t6_post_reset");
        do_req(1'b0, 32'h100, '0, "t6_rst_miss100");

        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 49) == 0) begin
                do_flush(1'b0, "rnd_flush");
            end else begin
                a = (32'($urandom_range(0, 7)) << 8) | (32'($urandom_range(0, 3)) << 2)
                    | 32'($urandom_range(0, 3));
                if ($urandom_range(0, 3) == 0) a = a | 32'h4000_0000;
                mem_lat = $urandom_range(0, 3);
                do_req(($urandom_range(0, 9) < 3), a, $urandom, "rnd");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
